// File: rtl/dm_axil_sram.sv
// dm_axil_sram: AXI-Lite data memory behind the load/store unit.
//   Word-organised SRAM with one byte-wide bank per strobe lane.
//   Has one-entry AW and W holding registers and one outstanding read.
//   Out-of-range accesses answer SLVERR: writes are dropped, reads return 0.
// Ports:
//   clk, rstn       - clock, synchronous active-low reset
//   s_aw*/s_w*/s_b* - write address, data and response channels
//   s_ar*/s_r*      - read address and data channels
//   s_awprot, s_arprot are accepted and ignored.

// One byte lane of the array. The read is registered and only loads on i_re,
// so the output holds while a response is stalled. On a same-edge read and
// write of one word, the read returns the pre-write data.
module dm_axil_sram_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_ridx,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2**AW];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
    if (i_re) r_q <= r_mem[i_ridx];
  end

  assign o_rdata = r_q;
endmodule

module dm_axil_sram #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [XLEN-1:0]   s_awaddr,
  input  logic [2:0]        s_awprot,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [XLEN-1:0]   s_wdata,
  input  logic [XLEN/8-1:0] s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [XLEN-1:0]   s_araddr,
  input  logic [2:0]        s_arprot,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [XLEN-1:0]   s_rdata,
  output logic [1:0]        s_rresp
);
  localparam int              NB   = XLEN / 8;
  localparam int              BL   = $clog2(NB);
  localparam int              AW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * NB);
  localparam logic [1:0]      OKAY = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;

  // The address is decoded once, when AW is accepted.
  typedef struct packed {
    logic            ok;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic [NB-1:0]   strb;
  } wr_req_t;

  wr_req_t             r_wr;
  logic                r_aw_full, r_w_full;
  logic                r_bvalid, r_rvalid, r_rzero;
  logic [1:0]          r_bresp, r_rresp;

  logic [XLEN-1:0]     w_aw_off, w_ar_off;
  logic                w_aw_ok, w_ar_ok;
  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [NB-1:0][7:0]  w_lane_q;
  logic                w_unused;

  // The unsigned subtraction wraps addresses below BASE_ADDR, so one compare
  // covers both ends of the window.
  assign w_aw_off = s_awaddr - BASE_ADDR;
  assign w_ar_off = s_araddr - BASE_ADDR;
  assign w_aw_ok  = w_aw_off < SPAN;
  assign w_ar_ok  = w_ar_off < SPAN;

  assign s_awready = rstn & ~r_aw_full;
  assign s_wready  = rstn & ~r_w_full;
  assign s_arready = rstn & (~r_rvalid | s_rready);

  assign w_aw_hs  = s_awvalid & s_awready;
  assign w_w_hs   = s_wvalid & s_wready;
  assign w_ar_hs  = s_arvalid & s_arready;
  // The rstn gate keeps a write held across reset out of the array.
  assign w_commit = rstn & r_aw_full & r_w_full & (~r_bvalid | s_bready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rzero   <= 1'b1;
    end else begin
      // A holding register cannot be accepted into and committed on the same edge.
      if (w_aw_hs)       r_aw_full <= 1'b1;
      else if (w_commit) r_aw_full <= 1'b0;
      if (w_w_hs)        r_w_full  <= 1'b1;
      else if (w_commit) r_w_full  <= 1'b0;

      // A commit in the same cycle as a B handshake keeps bvalid asserted.
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= r_wr.ok ? OKAY : SLVERR;
      end else if (s_bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_ar_ok ? OKAY : SLVERR;
        r_rzero  <= ~w_ar_ok;
      end else if (s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // The payload registers are qualified by the full flags and are not reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_wr.ok  <= w_aw_ok;
      r_wr.idx <= w_aw_off[BL +: AW];
    end
    if (w_w_hs) begin
      r_wr.data <= s_wdata;
      r_wr.strb <= s_wstrb;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    dm_axil_sram_lane #(.AW(AW)) u_lane (
      .clk     (clk),
      .i_we    (w_commit & r_wr.ok & r_wr.strb[g]),
      .i_widx  (r_wr.idx),
      .i_wdata (r_wr.data[8*g +: 8]),
      .i_re    (w_ar_hs & w_ar_ok),
      .i_ridx  (w_ar_off[BL +: AW]),
      .o_rdata (w_lane_q[g])
    );
  end

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign s_rvalid = r_rvalid;
  assign s_rresp  = r_rresp;
  assign s_rdata  = r_rzero ? '0 : w_lane_q;

  assign w_unused = ^{s_awprot, s_arprot};
endmodule
